// File: rtl/fetch_ir_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_ir_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DRAIN
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_ir_if.sv
// Instruction bus between the fetch stage (master) and memory (slave).
interface fetch_ir_if;

   logic        mem_valid;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid,
      output mem_addr,
      input  mem_ready,
      input  mem_rdata
   );

   modport slave (
      input  mem_valid,
      input  mem_addr,
      output mem_ready,
      output mem_rdata
   );

endinterface

// File: rtl/fetch_ir_watchdog.sv
// Cycle counter for the fetch stage; expired is high in the cycle that is the
// TIMEOUT_CYCLES-th consecutive cycle with run high. Used under FETCH_TIMEOUT_EN.
module fetch_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic resetn,
   input  logic run,
   output logic expired
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d   = run ? cnt_q + 1'b1 : '0;
      expired = run && (cnt_q == LIMIT);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/fetch_ir.sv
// Instruction fetch stage: one bus read per fetch_req, result held in instr.
// Optional bus watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_ir
   import fetch_ir_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR     = 32'h8000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        fetch_req,
   input  logic [31:0] pc,
   input  logic        flush,
   fetch_ir_if.master  mem,
   output logic [31:0] instr,
   output logic [31:0] old_pc,
   output logic        fetch_done,
   output logic        fetch_fault,
   output logic        busy
);

   fetch_state_e state_q, state_d;
   logic [31:0]  addr_q, addr_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  old_pc_q, old_pc_d;
   logic         done_q, done_d;
   logic         fault_q, fault_d;
   logic         wd_expired;

   assign busy = (state_q != ST_IDLE);

`ifdef FETCH_TIMEOUT_EN
   fetch_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
      .clk     (clk),
      .resetn  (resetn),
      .run     (busy),
      .expired (wd_expired)
   );
`else
   assign wd_expired = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      instr_d  = instr_q;
      old_pc_d = old_pc_q;
      done_d   = 1'b0;
      fault_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fetch_req && !flush) begin
               if (pc[1:0] == 2'b00) begin
                  addr_d  = pc;
                  state_d = ST_WAIT;
               end else begin
                  fault_d = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            // ready beats timeout; a timeout coinciding with flush stays silent
            if (mem.mem_ready) begin
               state_d = ST_IDLE;
               if (!flush) begin
                  instr_d  = mem.mem_rdata;
                  old_pc_d = addr_q;
                  done_d   = 1'b1;
               end
            end else if (wd_expired) begin
               state_d = ST_IDLE;
               fault_d = !flush;
            end else if (flush) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (mem.mem_ready || wd_expired) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         instr_q  <= NOP_INSTR;
         old_pc_q <= RESET_ADDR;
         done_q   <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         instr_q  <= instr_d;
         old_pc_q <= old_pc_d;
         done_q   <= done_d;
         fault_q  <= fault_d;
      end
   end

   assign mem.mem_valid = busy;
   assign mem.mem_addr  = addr_q;
   assign instr         = instr_q;
   assign old_pc        = old_pc_q;
   assign fetch_done    = done_q;
   assign fetch_fault   = fault_q;

endmodule
